ipd_port_scheduler: RTL and testbench

- Packet-granular round-robin scheduler that shares one AXI4-Stream datapath between NUM_PORTS generator streams.
- Each port carries its own inter-packet delay: after a port's packet ends, that port stays ineligible until its delay timer expires.
- Sits between the per-port packet sources and the single output toward the MAC/output queues.
- Configured from flat register vectors driven by the AXI-Lite register block.

---
 rtl/ipd_port_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ipd_port_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipd_port_scheduler.sv
`default_nettype none
// ==========================================================================
// Module   : ipd_port_scheduler
// Function : packet-granular round-robin over NUM_PORTS AXI4-Stream sources,
//            each port held off by its own inter-packet delay timer
// Revision : 1.0
// ==========================================================================
module ipd_port_scheduler #(
   parameter int NUM_PORTS            = 4,
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXI_DATA_WIDTH   = 32
) (
   input  logic                                          axi_aclk,
   input  logic                                          axi_aresetn,
   input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
   input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic [NUM_PORTS-1:0]                          s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                          s_axis_tlast,
   output logic [NUM_PORTS-1:0]                          s_axis_tready,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
   output logic                                          m_axis_tvalid,
   output logic                                          m_axis_tlast,
   input  logic                                          m_axis_tready,
   input  logic                                          sw_rst,
   input  logic                                          sched_en,
   input  logic [NUM_PORTS-1:0]                          port_en,
   input  logic [NUM_PORTS*C_S_AXI_DATA_WIDTH-1:0]       delay_reg_val,
   output logic [$clog2(NUM_PORTS)-1:0]                  grant_id,
   output logic                                          busy
);

   localparam int c_gw = $clog2(NUM_PORTS);
   localparam int c_dw = C_S_AXIS_DATA_WIDTH;
   localparam int c_sw = C_S_AXIS_DATA_WIDTH / 8;
   localparam int c_uw = C_S_AXIS_TUSER_WIDTH;
   localparam int c_tw = C_S_AXI_DATA_WIDTH;
   localparam logic [c_gw-1:0] c_last_port = c_gw'(NUM_PORTS - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PKT  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_gw-1:0]     r_grant_id;
   logic [c_gw-1:0]     r_last_grant;
   logic [c_gw-1:0]     w_pick;
   logic [c_gw:0]       w_idx;
   logic                w_found;
   logic                w_xfer_last;
   logic [NUM_PORTS-1:0] w_elig;
   logic [c_tw-1:0]     r_timer [NUM_PORTS];
   logic [c_tw-1:0]     w_delay [NUM_PORTS];
   logic [c_dw-1:0]     w_tdata [NUM_PORTS];
   logic [c_sw-1:0]     w_tstrb [NUM_PORTS];
   logic [c_uw-1:0]     w_tuser [NUM_PORTS];

   generate
      for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
         assign w_tdata[p] = s_axis_tdata[p*c_dw +: c_dw];
         assign w_tstrb[p] = s_axis_tstrb[p*c_sw +: c_sw];
         assign w_tuser[p] = s_axis_tuser[p*c_uw +: c_uw];
         assign w_delay[p] = delay_reg_val[p*c_tw +: c_tw];
         assign w_elig[p]  = port_en[p] & s_axis_tvalid[p] & (r_timer[p] == '0) & sched_en;
      end
   endgenerate

   // Search starts one past the previous winner and wraps modulo NUM_PORTS.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_last_grant;
      w_idx   = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         w_idx = {1'b0, r_last_grant} + (c_gw+1)'(i);
         if (w_idx >= (c_gw+1)'(NUM_PORTS)) begin
            w_idx = w_idx - (c_gw+1)'(NUM_PORTS);
         end
         if (!w_found && w_elig[w_idx[c_gw-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[c_gw-1:0];
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_xfer_last   = 1'b0;
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      busy          = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_PKT;
            end
         end
         ST_PKT: begin
            busy                      = 1'b1;
            m_axis_tvalid             = s_axis_tvalid[r_grant_id];
            m_axis_tlast              = s_axis_tlast[r_grant_id];
            s_axis_tready[r_grant_id] = m_axis_tready;
            if (s_axis_tvalid[r_grant_id] && m_axis_tready && s_axis_tlast[r_grant_id]) begin
               w_xfer_last = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign m_axis_tdata = w_tdata[r_grant_id];
   assign m_axis_tstrb = w_tstrb[r_grant_id];
   assign m_axis_tuser = w_tuser[r_grant_id];
   assign grant_id     = r_grant_id;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= c_last_port;
      end else if (sw_rst) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= c_last_port;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && w_found) begin
            r_grant_id   <= w_pick;
            r_last_grant <= w_pick;
         end
      end
   end

   // A reload on the closing beat wins over the free-running decrement.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         for (int p = 0; p < NUM_PORTS; p++) r_timer[p] <= '0;
      end else if (sw_rst) begin
         for (int p = 0; p < NUM_PORTS; p++) r_timer[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_xfer_last && (r_grant_id == c_gw'(p))) begin
               r_timer[p] <= w_delay[p];
            end else if (r_timer[p] != '0) begin
               r_timer[p] <= r_timer[p] - c_tw'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ipd_port_scheduler.sv
`default_nettype none
// Bench for ipd_port_scheduler: directed and randomized traffic checked
// against a packet/timestamp model of the scheduler.
module tb_ipd_port_scheduler;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int UW = 16;
   localparam int TW = 32;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [UW-1:0] user;
      logic          last;
   } beat_t;

   logic              clk = 1'b0;
   logic              aresetn;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*SW-1:0]  s_tstrb;
   logic [NP*UW-1:0]  s_tuser;
   logic [NP-1:0]     s_tvalid;
   logic [NP-1:0]     s_tlast;
   logic [NP-1:0]     s_tready;
   logic [DW-1:0]     m_tdata;
   logic [SW-1:0]     m_tstrb;
   logic [UW-1:0]     m_tuser;
   logic              m_tvalid;
   logic              m_tlast;
   logic              m_tready;
   logic              sw_rst;
   logic              sched_en;
   logic [NP-1:0]     port_en;
   logic [NP*TW-1:0]  delay_reg_val;
   logic [1:0]        grant_id;
   logic              busy;

   ipd_port_scheduler #(
      .NUM_PORTS           (NP),
      .C_M_AXIS_DATA_WIDTH (DW),
      .C_S_AXIS_DATA_WIDTH (DW),
      .C_M_AXIS_TUSER_WIDTH(UW),
      .C_S_AXIS_TUSER_WIDTH(UW),
      .C_S_AXI_DATA_WIDTH  (TW)
   ) dut (
      .axi_aclk     (clk),
      .axi_aresetn  (aresetn),
      .s_axis_tdata (s_tdata),
      .s_axis_tstrb (s_tstrb),
      .s_axis_tuser (s_tuser),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tlast (s_tlast),
      .s_axis_tready(s_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tstrb (m_tstrb),
      .m_axis_tuser (m_tuser),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tlast (m_tlast),
      .m_axis_tready(m_tready),
      .sw_rst       (sw_rst),
      .sched_en     (sched_en),
      .port_en      (port_en),
      .delay_reg_val(delay_reg_val),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int          n_vec;
   int          n_err;
   int          cyc;
   beat_t       srcq [NP][$];
   int unsigned dly [NP];
   bit          gaps;
   bit          bp;
   // model: owning port (-1 = none), previous winner, reported grant,
   // and the first cycle each port's delay has fully elapsed
   int          m_owner;
   int          m_last;
   int          m_gid;
   int          m_ready_at [NP];
   // packets seen on the DUT output
   int          obs_start_cyc [$];
   int          obs_start_port [$];
   int          obs_last_cyc [$];
   int          obs_len [$];
   bit          obs_in;
   int          obs_cur;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic add_pkt(input int p, input int len);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = $urandom;
         b.strb = SW'($urandom);
         b.user = UW'($urandom);
         b.last = (i == len - 1);
         srcq[p].push_back(b);
      end
   endtask

   function automatic bit all_empty();
      bit e = 1'b1;
      for (int p = 0; p < NP; p++) if (srcq[p].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic clear_obs();
      obs_start_cyc.delete();
      obs_start_port.delete();
      obs_last_cyc.delete();
      obs_len.delete();
      obs_in  = 1'b0;
      obs_cur = 0;
   endtask

   task automatic drive(input bit swr);
      beat_t b;
      sw_rst = swr;
      for (int p = 0; p < NP; p++) begin
         b = '0;
         if (srcq[p].size() > 0) b = srcq[p][0];
         s_tvalid[p]             = (srcq[p].size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
         s_tdata[p*DW +: DW]     = b.data;
         s_tstrb[p*SW +: SW]     = b.strb;
         s_tuser[p*UW +: UW]     = b.user;
         s_tlast[p]              = b.last;
         delay_reg_val[p*TW +: TW] = dly[p];
      end
      m_tready = !bp || ($urandom_range(0, 1) == 1);
   endtask

   task automatic check_cycle();
      logic [NP-1:0] exp_rdy;
      bit            exp_v;
      beat_t         b;
      int            exp_t;
      exp_rdy = '0;
      exp_v   = 1'b0;
      if (m_owner >= 0) begin
         exp_v = s_tvalid[m_owner];
         if (m_tready) exp_rdy[m_owner] = 1'b1;
      end
      check("busy", busy, m_owner >= 0);
      check("m_tvalid", m_tvalid, exp_v);
      check("s_tready", s_tready, exp_rdy);
      check("grant_id", grant_id, m_gid);
      if (exp_v) begin
         b = srcq[m_owner][0];
         check("m_tdata", m_tdata, b.data);
         check("m_tstrb", m_tstrb, b.strb);
         check("m_tuser", m_tuser, b.user);
         check("m_tlast", m_tlast, b.last);
      end
      for (int p = 0; p < NP; p++) begin
         exp_t = (m_ready_at[p] > cyc) ? (m_ready_at[p] - cyc) : 0;
         check("timer", dut.r_timer[p], exp_t);
      end
      if (m_tvalid === 1'b1 && m_tready) begin
         if (!obs_in) begin
            obs_start_cyc.push_back(cyc);
            obs_start_port.push_back(int'(grant_id));
            obs_cur = 0;
            obs_in  = 1'b1;
         end
         obs_cur++;
         if (m_tlast === 1'b1) begin
            obs_last_cyc.push_back(cyc);
            obs_len.push_back(obs_cur);
            obs_in = 1'b0;
         end
      end
   endtask

   task automatic advance(input bit swr);
      beat_t b;
      int    p;
      if (swr) begin
         m_owner = -1;
         m_last  = NP - 1;
         m_gid   = 0;
         for (int k = 0; k < NP; k++) m_ready_at[k] = 0;
      end else if (m_owner >= 0) begin
         if (s_tvalid[m_owner] && m_tready) begin
            b = srcq[m_owner].pop_front();
            if (b.last) begin
               m_ready_at[m_owner] = cyc + 1 + int'(dly[m_owner]);
               m_owner = -1;
            end
         end
      end else if (sched_en) begin
         for (int i = 1; i <= NP; i++) begin
            p = (m_last + i) % NP;
            if (m_owner < 0 && port_en[p] && s_tvalid[p] && cyc >= m_ready_at[p]) begin
               m_owner = p;
               m_gid   = p;
               m_last  = p;
            end
         end
      end
   endtask

   task automatic step(input bit swr);
      drive(swr);
      #1;
      check_cycle();
      advance(swr);
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic reset_sched();
      step(1'b1);
      for (int p = 0; p < NP; p++) srcq[p].delete();
      clear_obs();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (!all_empty() && n < budget) begin
         step(1'b0);
         n++;
      end
      check(tag, all_empty(), 1'b1);
      repeat (3) step(1'b0);
   endtask

   initial begin
      int exp_order [$];
      int prev1;
      int cnt0;
      int n1;
      int n;
      n_vec = 0; n_err = 0; cyc = 0;
      aresetn = 1'b0; sw_rst = 1'b0; sched_en = 1'b1; port_en = '0; m_tready = 1'b0;
      s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = '0; s_tlast = '0; delay_reg_val = '0;
      gaps = 1'b0; bp = 1'b0;
      m_owner = -1; m_last = NP - 1; m_gid = 0;
      for (int p = 0; p < NP; p++) begin dly[p] = 0; m_ready_at[p] = 0; end
      clear_obs();

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_tvalid", m_tvalid, 1'b0);
      check("rst_tready", s_tready, '0);
      check("rst_grant", grant_id, 2'd0);
      check("rst_timer", dut.r_timer[0], 0);
      @(negedge clk) aresetn = 1'b1;
      @(posedge clk);
      #1;

      // single port, D=0, three back-to-back 4-beat packets
      port_en = 4'b0001;
      repeat (3) add_pkt(0, 4);
      drain("s1_drain", 100);
      check("s1_npkt", obs_len.size(), 3);
      for (int i = 0; i < obs_len.size(); i++) begin
         check("s1_len", obs_len[i], 4);
         check("s1_port", obs_start_port[i], 0);
         if (i > 0) check("s1_gap", obs_start_cyc[i] - obs_last_cyc[i-1], 2);
      end

      // delay of 10 on port 1
      reset_sched();
      port_en = 4'b0010; dly[1] = 10;
      add_pkt(1, 2); add_pkt(1, 2);
      drain("s2_drain", 100);
      check("s2_npkt", obs_len.size(), 2);
      if (obs_len.size() >= 2) check("s2_spacing", obs_start_cyc[1] - obs_last_cyc[0], 12);

      // round-robin across all ports, then only ports 1 and 3
      reset_sched();
      port_en = 4'b1111; dly[1] = 0;
      for (int k = 0; k < 2; k++) for (int p = 0; p < NP; p++) add_pkt(p, 1);
      drain("s3_drain", 100);
      check("s3_npkt", obs_start_port.size(), 8);
      for (int i = 0; i < obs_start_port.size(); i++) begin
         check("s3_order", obs_start_port[i], i % 4);
         if (i > 0) check("s3_spacing", obs_start_cyc[i] - obs_start_cyc[i-1], 2);
      end
      reset_sched();
      port_en = 4'b1010;
      for (int k = 0; k < 2; k++) begin add_pkt(1, 1); add_pkt(3, 1); end
      drain("s3b_drain", 100);
      exp_order = '{1, 3, 1, 3};
      check("s3b_npkt", obs_start_port.size(), 4);
      for (int i = 0; i < obs_start_port.size() && i < 4; i++) check("s3b_order", obs_start_port[i], exp_order[i]);

      // mixed delays: port 0 D=0, port 1 D=20, continuous traffic
      reset_sched();
      port_en = 4'b0011; dly[0] = 0; dly[1] = 20;
      for (int k = 0; k < 150; k++) add_pkt(0, 1);
      for (int k = 0; k < 15; k++) add_pkt(1, 1);
      repeat (220) step(1'b0);
      prev1 = -1; cnt0 = 0; n1 = 0;
      for (int i = 0; i < obs_start_port.size(); i++) begin
         if (obs_start_port[i] == 1) begin
            if (prev1 >= 0) begin
               check("s4_spacing_ge22", (obs_start_cyc[i] - prev1) >= 22, 1'b1);
               check("s4_ratio", (cnt0 >= 9) && (cnt0 <= 11), 1'b1);
            end
            prev1 = obs_start_cyc[i]; cnt0 = 0; n1++;
         end else begin
            cnt0++;
         end
      end
      check("s4_port1_pkts", n1 >= 5, 1'b1);

      // backpressure on an 8-beat packet from port 2
      reset_sched();
      port_en = 4'b0100; dly[1] = 0; bp = 1'b1;
      add_pkt(2, 8);
      drain("s5_drain", 300);
      check("s5_npkt", obs_len.size(), 1);
      if (obs_len.size() == 1) check("s5_len", obs_len[0], 8);
      bp = 1'b0;

      // soft reset mid-packet
      reset_sched();
      port_en = 4'b0001;
      add_pkt(0, 8);
      n = 0;
      while (!(obs_in && obs_cur >= 3) && n < 50) begin step(1'b0); n++; end
      check("s6_reach", obs_in && obs_cur >= 3, 1'b1);
      step(1'b1);
      check("s6_busy", busy, 1'b0);
      check("s6_tvalid", m_tvalid, 1'b0);
      for (int p = 0; p < NP; p++) srcq[p].delete();
      clear_obs();

      // soft reset with a long timer pending, then first grant
      port_en = 4'b0010; dly[1] = 500;
      add_pkt(1, 1);
      repeat (20) step(1'b0);
      check("s6_timer_live", dut.r_timer[1] != 0, 1'b1);
      reset_sched();
      check("s6_timer_clr", dut.r_timer[1], 0);
      port_en = 4'b1111; dly[1] = 0;
      for (int p = 0; p < NP; p++) add_pkt(p, 1);
      drain("s6_drain", 100);
      check("s6_npkt", obs_start_port.size(), 4);
      if (obs_start_port.size() > 0) check("s6_first", obs_start_port[0], 0);

      // randomized traffic, enables, delays and backpressure
      reset_sched();
      gaps = 1'b1; bp = 1'b1; port_en = 4'b1111;
      for (int p = 0; p < NP; p++) dly[p] = $urandom_range(0, 15);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 49) == 0) port_en = NP'($urandom);
         if ($urandom_range(0, 99) == 0) sched_en = ~sched_en;
         if ($urandom_range(0, 199) == 0) dly[$urandom_range(0, NP-1)] = $urandom_range(0, 15);
         for (int p = 0; p < NP; p++) if (srcq[p].size() < 4) add_pkt(p, $urandom_range(1, 6));
         step(1'b0);
      end
      gaps = 1'b0; bp = 1'b0; sched_en = 1'b1;
      reset_sched();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
